// File: rtl/bus_burst_slave_ram_if.sv
// bus_burst_slave_ram_if: burst bus between a DMA master and the scratch RAM slave.
interface bus_burst_slave_ram_if;
   logic        in_beginTransaction;
   logic        in_endTransaction;
   logic        in_readNotWrite;
   logic [31:0] in_addressData;
   logic [7:0]  in_burstSize;
   logic [3:0]  in_byteEnable;
   logic        in_dataValid;
   logic [31:0] out_addressData;
   logic        out_dataValid;
   logic        out_endTransaction;
   logic        out_busy;
   logic        out_busError;
   modport master (
      output in_beginTransaction, in_endTransaction, in_readNotWrite, in_addressData,
             in_burstSize, in_byteEnable, in_dataValid,
      input  out_addressData, out_dataValid, out_endTransaction, out_busy, out_busError
   );
   modport slave (
      input  in_beginTransaction, in_endTransaction, in_readNotWrite, in_addressData,
             in_burstSize, in_byteEnable, in_dataValid,
      output out_addressData, out_dataValid, out_endTransaction, out_busy, out_busError
   );
endinterface

// File: rtl/bus_burst_slave_ram.sv
// bus_burst_slave_ram: burst read/write bus slave backed by a local 32-bit RAM.
// Define BUS_SLAVE_BUSY_INJECT_EN to insert a one-cycle busy after every 4th write beat.
module bus_burst_slave_ram #(
   parameter logic [31:0] BASE_ADDR = 32'h5000_0000,
   parameter int          ADDR_W    = 9
) (
   input logic                  clk,
   input logic                  rst_n,
   bus_burst_slave_ram_if.slave bus
);
   localparam int DEPTH = 2 ** ADDR_W;
   typedef enum logic [2:0] {IDLE, READ, RDONE, WRITE, ERROR} state_t;
   state_t            state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d, idx, addr;
   logic [7:0]        size_q, size_d, cnt_q, cnt_d;
   logic [3:0]        be_q, be_d;
   logic              done_q, done_d;
   logic [31:0]       rdata_q;
   logic              dv_q, dv_d, end_q, end_d, busy_q, busy_d, err_q, err_d;
   logic              rd_en, wr_en, hit, over;
   logic [ADDR_W:0]   last;
   logic              unused_lsb;
   logic [31:0]       mem [DEPTH];
   assign idx        = bus.in_addressData[ADDR_W+1:2];
   assign hit        = bus.in_addressData[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2];
   assign last       = {1'b0, idx} + (ADDR_W+1)'(bus.in_burstSize);
   assign over       = last > (ADDR_W+1)'(DEPTH - 1);
   assign addr       = base_q + ADDR_W'(cnt_q);
   assign unused_lsb = ^bus.in_addressData[1:0];
   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      size_d  = size_q;
      be_d    = be_q;
      cnt_d   = cnt_q;
      done_d  = done_q;
      dv_d    = 1'b0;
      end_d   = 1'b0;
      busy_d  = 1'b0;
      err_d   = 1'b0;
      rd_en   = 1'b0;
      wr_en   = 1'b0;
      case (state_q)
         IDLE: if (bus.in_beginTransaction && hit) begin
            base_d  = idx;
            size_d  = bus.in_burstSize;
            be_d    = bus.in_byteEnable;
            cnt_d   = '0;
            done_d  = 1'b0;
            err_d   = over;
            state_d = over ? ERROR : bus.in_readNotWrite ? READ : WRITE;
         end
         READ: if (bus.in_endTransaction) state_d = IDLE;
         else begin
            rd_en   = 1'b1;
            dv_d    = 1'b1;
            cnt_d   = cnt_q + 8'd1;
            state_d = cnt_q == size_q ? RDONE : READ;
         end
         RDONE: begin
            end_d   = !bus.in_endTransaction;
            state_d = IDLE;
         end
         WRITE: begin
            // a beat offered while busy is showing is held by the master, not taken
            wr_en  = bus.in_dataValid && !busy_q && !done_q;
            cnt_d  = wr_en ? cnt_q + 8'd1 : cnt_q;
            done_d = done_q || (wr_en && cnt_q == size_q);
`ifdef BUS_SLAVE_BUSY_INJECT_EN
            busy_d = wr_en && &cnt_q[1:0] && !bus.in_endTransaction;
`else
            busy_d = 1'b0;
`endif
            state_d = bus.in_endTransaction ? IDLE : WRITE;
         end
         ERROR:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         base_q  <= '0;
         size_q  <= '0;
         be_q    <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         rdata_q <= '0;
         dv_q    <= 1'b0;
         end_q   <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         size_q  <= size_d;
         be_q    <= be_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         rdata_q <= rd_en ? mem[addr] : '0;
         dv_q    <= dv_d;
         end_q   <= end_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
      end
   end
   always_ff @(posedge clk)
      if (wr_en)
         for (int b = 0; b < 4; b++)
            if (be_q[b]) mem[addr][8*b +: 8] <= bus.in_addressData[8*b +: 8];
   assign bus.out_addressData    = rdata_q;
   assign bus.out_dataValid      = dv_q;
   assign bus.out_endTransaction = end_q;
   assign bus.out_busy           = busy_q;
   assign bus.out_busError       = err_q;
endmodule

// File: tb/tb_bus_burst_slave_ram.sv
// tb_bus_burst_slave_ram: cycle-table and directed-sequence bench for bus_burst_slave_ram.
module tb_bus_burst_slave_ram;
   localparam logic [31:0] B = 32'h5000_0000;
`ifdef BUS_SLAVE_BUSY_INJECT_EN
   localparam logic BUSY_EN = 1'b1;
`else
   localparam logic BUSY_EN = 1'b0;
`endif
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_pass = 0;
   int   n_tot = 0;
   bus_burst_slave_ram_if bus ();
   bus_burst_slave_ram #(.BASE_ADDR(B), .ADDR_W(9)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   // ctl = {begin, end, readNotWrite, dataValid}; eo = {dataValid, end, busy, error}
   typedef struct {
      logic [3:0]  ctl;
      logic [31:0] ad;
      logic [7:0]  sz;
      logic [3:0]  be;
      logic [3:0]  eo;
      logic [31:0] ed;
   } vec_t;
   vec_t vq[$];
   task automatic p(input logic [3:0] ctl, input logic [31:0] ad, input logic [7:0] sz,
                    input logic [3:0] be, input logic [3:0] eo, input logic [31:0] ed);
      vq.push_back('{ctl, ad, sz, be, eo, ed});
   endtask
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask
   task automatic drive(input logic [3:0] ctl, input logic [31:0] ad, input logic [7:0] sz,
                        input logic [3:0] be);
      {bus.in_beginTransaction, bus.in_endTransaction, bus.in_readNotWrite, bus.in_dataValid} = ctl;
      bus.in_addressData = ad;
      bus.in_burstSize   = sz;
      bus.in_byteEnable  = be;
   endtask
   function automatic logic [35:0] outs();
      return {bus.out_dataValid, bus.out_endTransaction, bus.out_busy, bus.out_busError,
              bus.out_addressData};
   endfunction
   task automatic write_chk(input logic [31:0] a, input int n, input logic [3:0] be,
                            input logic [31:0] d);
      int  i = 0;
      int  cyc = 0;
      int  nb = 0;
      logic hold;
      @(negedge clk);
      drive(4'b1000, a, 8'(n - 1), be);
      while (i < n && cyc < 3 * n + 4) begin
         @(negedge clk);
         hold = bus.out_busy;
         nb += int'(hold);
         drive(4'b0001, d, 8'(n - 1), be);
         cyc++;
         if (!hold) i++;
      end
      @(negedge clk);
      nb += int'(bus.out_busy);
      drive(4'b0100, '0, '0, '0);
      @(negedge clk);
      drive(4'b0000, '0, '0, '0);
      chk("wr_beats", 64'(i), 64'(n));
      chk("wr_busy_pulses", 64'(nb), BUSY_EN ? 64'(n / 4) : 64'd0);
   endtask
   task automatic read_chk(input logic [31:0] a, input int n, input logic [31:0] ev);
      @(negedge clk);
      drive(4'b1010, a, 8'(n - 1), 4'hF);
      @(negedge clk);
      drive(4'b0000, '0, '0, '0);
      chk("rd_latency", 64'(outs()), 64'd0);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         chk($sformatf("rd_beat%0d", k), 64'(outs()), 64'({4'b1000, ev}));
      end
      @(negedge clk);
      chk("rd_end_pulse", 64'(outs()), 64'({4'b0100, 32'h0}));
      @(negedge clk);
      chk("rd_after_end", 64'(outs()), 64'd0);
   endtask
   initial begin
      drive(4'b0000, '0, '0, '0);
      // write 4..7, read back, ignored begin mid-read, end in IDLE
      p(4'b1000, B + 32'h10, 8'd3, 4'hF, 4'b0000, 0);
      p(4'b0001, 32'hA0, 8'd0, 4'h0, 4'b0000, 0);
      p(4'b0001, 32'hA1, 8'd0, 4'h0, 4'b0000, 0);
      p(4'b0001, 32'hA2, 8'd0, 4'h0, 4'b0000, 0);
      p(4'b0001, 32'hA3, 8'd0, 4'h0, 4'b0000, 0);
      p(4'b0100, 0, 8'd0, 4'h0, {2'b00, BUSY_EN, 1'b0}, 0);
      p(4'b0000, 0, 8'd0, 4'h0, 4'b0000, 0);
      p(4'b1010, B + 32'h10, 8'd3, 4'hF, 4'b0000, 0);
      p(4'b0000, 0, 8'd0, 4'h0, 4'b0000, 0);
      p(4'b1000, B + 32'h7F8, 8'd3, 4'hF, 4'b1000, 32'hA0);
      p(4'b0000, 0, 8'd0, 4'h0, 4'b1000, 32'hA1);
      p(4'b0000, 0, 8'd0, 4'h0, 4'b1000, 32'hA2);
      p(4'b0000, 0, 8'd0, 4'h0, 4'b1000, 32'hA3);
      p(4'b0000, 0, 8'd0, 4'h0, 4'b0100, 0);
      p(4'b0100, 0, 8'd0, 4'h0, 4'b0000, 0);
      p(4'b0000, 0, 8'd0, 4'h0, 4'b0000, 0);
      // top-of-RAM write (510,511), then out-of-range begins
      p(4'b1000, B + 32'h7F8, 8'd1, 4'hF, 4'b0000, 0);
      p(4'b0001, 32'h1111_1111, 8'd0, 4'h0, 4'b0000, 0);
      p(4'b0001, 32'h2222_2222, 8'd0, 4'h0, 4'b0000, 0);
      p(4'b0100, 0, 8'd0, 4'h0, 4'b0000, 0);
      p(4'b1000, B + 32'h7F8, 8'd3, 4'hF, 4'b0000, 0);
      p(4'b0001, 32'h9999_9999, 8'd0, 4'h0, 4'b0001, 0);
      p(4'b0001, 32'h9999_9999, 8'd0, 4'h0, 4'b0000, 0);
      p(4'b1010, B + 32'h7FC, 8'd1, 4'hF, 4'b0000, 0);
      p(4'b0000, 0, 8'd0, 4'h0, 4'b0001, 0);
      p(4'b1010, B + 32'h7F8, 8'd1, 4'hF, 4'b0000, 0);
      p(4'b0000, 0, 8'd0, 4'h0, 4'b0000, 0);
      p(4'b0000, 0, 8'd0, 4'h0, 4'b1000, 32'h1111_1111);
      p(4'b0000, 0, 8'd0, 4'h0, 4'b1000, 32'h2222_2222);
      p(4'b0000, 0, 8'd0, 4'h0, 4'b0100, 0);
      // window miss, then a single-beat hit read
      p(4'b1010, 32'h4000_0010, 8'd3, 4'hF, 4'b0000, 0);
      p(4'b0000, 0, 8'd0, 4'h0, 4'b0000, 0);
      p(4'b0000, 0, 8'd0, 4'h0, 4'b0000, 0);
      p(4'b1010, B + 32'h14, 8'd0, 4'hF, 4'b0000, 0);
      p(4'b0000, 0, 8'd0, 4'h0, 4'b0000, 0);
      p(4'b0000, 0, 8'd0, 4'h0, 4'b1000, 32'hA1);
      p(4'b0000, 0, 8'd0, 4'h0, 4'b0100, 0);
      // read aborted by the master after beat 0
      p(4'b1010, B + 32'h10, 8'd3, 4'hF, 4'b0000, 0);
      p(4'b0000, 0, 8'd0, 4'h0, 4'b0000, 0);
      p(4'b0100, 0, 8'd0, 4'h0, 4'b1000, 32'hA0);
      p(4'b0000, 0, 8'd0, 4'h0, 4'b0000, 0);
      p(4'b0000, 0, 8'd0, 4'h0, 4'b0000, 0);
      // short write ended with a beat in the end cycle
      p(4'b1000, B + 32'h20, 8'd3, 4'hF, 4'b0000, 0);
      p(4'b0001, 32'hB0, 8'd0, 4'h0, 4'b0000, 0);
      p(4'b0001, 32'hB1, 8'd0, 4'h0, 4'b0000, 0);
      p(4'b0101, 32'hB2, 8'd0, 4'h0, 4'b0000, 0);
      p(4'b1010, B + 32'h20, 8'd2, 4'hF, 4'b0000, 0);
      p(4'b0000, 0, 8'd0, 4'h0, 4'b0000, 0);
      p(4'b0000, 0, 8'd0, 4'h0, 4'b1000, 32'hB0);
      p(4'b0000, 0, 8'd0, 4'h0, 4'b1000, 32'hB1);
      p(4'b0000, 0, 8'd0, 4'h0, 4'b1000, 32'hB2);
      p(4'b0000, 0, 8'd0, 4'h0, 4'b0100, 0);
      // beats past size+1 are dropped
      p(4'b1000, B + 32'h30, 8'd1, 4'hF, 4'b0000, 0);
      p(4'b0001, 32'hD0, 8'd0, 4'h0, 4'b0000, 0);
      p(4'b0001, 32'hD1, 8'd0, 4'h0, 4'b0000, 0);
      p(4'b0100, 0, 8'd0, 4'h0, 4'b0000, 0);
      p(4'b1000, B + 32'h30, 8'd0, 4'hF, 4'b0000, 0);
      p(4'b0001, 32'hE0, 8'd0, 4'h0, 4'b0000, 0);
      p(4'b0001, 32'hE1, 8'd0, 4'h0, 4'b0000, 0);
      p(4'b0100, 0, 8'd0, 4'h0, 4'b0000, 0);
      p(4'b1010, B + 32'h30, 8'd1, 4'hF, 4'b0000, 0);
      p(4'b0000, 0, 8'd0, 4'h0, 4'b0000, 0);
      p(4'b0000, 0, 8'd0, 4'h0, 4'b1000, 32'hE0);
      p(4'b0000, 0, 8'd0, 4'h0, 4'b1000, 32'hD1);
      p(4'b0000, 0, 8'd0, 4'h0, 4'b0100, 0);
      p(4'b0000, 0, 8'd0, 4'h0, 4'b0000, 0);
      repeat (2) @(negedge clk);
      chk("reset_outputs", 64'(outs()), 64'd0);
      rst_n = 1'b1;
      foreach (vq[i]) begin
         @(negedge clk);
         chk($sformatf("vec%0d", i), 64'(outs()), 64'({vq[i].eo, vq[i].ed}));
         drive(vq[i].ctl, vq[i].ad, vq[i].sz, vq[i].be);
      end
      // byte-enabled write over an all-ones burst, busy-aware
      write_chk(B + 32'h80, 8, 4'hF, 32'hFFFF_FFFF);
      write_chk(B + 32'h80, 8, 4'b0011, 32'h1234_5678);
      read_chk(B + 32'h80, 8, 32'hFFFF_5678);
      // reset asserted while beat 2 of a read is on the bus
      @(negedge clk);
      drive(4'b1010, B + 32'h80, 8'd7, 4'hF);
      @(negedge clk);
      drive(4'b0000, '0, '0, '0);
      repeat (3) @(negedge clk);
      chk("pre_reset_beat2", 64'(outs()), 64'({4'b1000, 32'hFFFF_5678}));
      rst_n = 1'b0;
      #1;
      chk("async_reset_outs", 64'(outs()), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("post_reset_idle", 64'(outs()), 64'd0);
      end
      read_chk(B + 32'h10, 1, 32'hA0);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
